// File: rtl/inst_fetch_buffer.sv
// Dual-issue instruction fetch buffer.
// Circular FIFO between the ICache response and the two decoders. Up to two
// fetched entries are compacted into the tail each cycle, and the two oldest
// entries are presented first-word-fall-through. A flush clears the queue.
module inst_fetch_buffer #(
  parameter int DEPTH   = 8,
  parameter int PTR_W   = 3,
  parameter int CAUSE_W = 7
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic [1:0]         fetch_valid,
  input  logic [31:0]        fetch_pc0,
  input  logic [31:0]        fetch_inst0,
  input  logic               fetch_exc0,
  input  logic [CAUSE_W-1:0] fetch_cause0,
  input  logic [31:0]        fetch_pc1,
  input  logic [31:0]        fetch_inst1,
  input  logic               fetch_exc1,
  input  logic [CAUSE_W-1:0] fetch_cause1,
  output logic               fetch_ready,
  output logic [1:0]         dec_valid,
  output logic [31:0]        dec_pc0,
  output logic [31:0]        dec_inst0,
  output logic               dec_exc0,
  output logic [CAUSE_W-1:0] dec_cause0,
  output logic [31:0]        dec_pc1,
  output logic [31:0]        dec_inst1,
  output logic               dec_exc1,
  output logic [CAUSE_W-1:0] dec_cause1,
  input  logic [1:0]         dec_ready,
  output logic [PTR_W:0]     occupancy
);

  localparam int CW = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CW-1:0]    MAX_FILL = CW'(DEPTH - 2);

  logic [31:0]        pc_q    [DEPTH];
  logic [31:0]        inst_q  [DEPTH];
  logic               exc_q   [DEPTH];
  logic [CAUSE_W-1:0] cause_q [DEPTH];

  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;

  logic             push0, push1, pop0, pop1;
  logic [CW-1:0]    n_push, n_pop;
  logic [PTR_W-1:0] head_p1, tail_p1;
  logic             wr0, wr1;
  logic [31:0]        wr0_pc, wr0_inst;
  logic               wr0_exc;
  logic [CAUSE_W-1:0] wr0_cause;

  // Space check and slot validity come straight from the count register.
  assign fetch_ready = (count_q <= MAX_FILL);
  assign dec_valid   = {(count_q >= CW'(2)), (count_q >= CW'(1))};
  assign occupancy   = count_q;
  assign head_p1     = head_q + PTR_ONE;
  assign tail_p1     = tail_q + PTR_ONE;

  // Push/pop decisions, compaction select and next pointer/count values.
  always_comb begin
    push0  = fetch_ready & fetch_valid[0];
    push1  = fetch_ready & fetch_valid[1];
    pop0   = dec_valid[0] & dec_ready[0];
    pop1   = pop0 & dec_valid[1] & dec_ready[1];
    n_push = CW'(push0) + CW'(push1);
    n_pop  = CW'(pop0) + CW'(pop1);

    // A lone slot-1 packet lands in the tail so the queue stays hole-free.
    wr0       = ~flush & (push0 | push1);
    wr1       = ~flush & push0 & push1;
    wr0_pc    = fetch_valid[0] ? fetch_pc0    : fetch_pc1;
    wr0_inst  = fetch_valid[0] ? fetch_inst0  : fetch_inst1;
    wr0_exc   = fetch_valid[0] ? fetch_exc0   : fetch_exc1;
    wr0_cause = fetch_valid[0] ? fetch_cause0 : fetch_cause1;

    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + n_pop[PTR_W-1:0];
      tail_d  = tail_q + n_push[PTR_W-1:0];
      count_d = count_q + n_push - n_pop;
    end
  end

  // Pointer and count registers; flush is folded into the next-state values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (wr0) begin
      pc_q[tail_q]    <= wr0_pc;
      inst_q[tail_q]  <= wr0_inst;
      exc_q[tail_q]   <= wr0_exc;
      cause_q[tail_q] <= wr0_cause;
    end
    if (wr1) begin
      pc_q[tail_p1]    <= fetch_pc1;
      inst_q[tail_p1]  <= fetch_inst1;
      exc_q[tail_p1]   <= fetch_exc1;
      cause_q[tail_p1] <= fetch_cause1;
    end
  end

  // Decoder-facing view of the two oldest entries, zeroed when not valid.
  always_comb begin
    dec_pc0    = dec_valid[0] ? pc_q[head_q]     : '0;
    dec_inst0  = dec_valid[0] ? inst_q[head_q]   : '0;
    dec_exc0   = dec_valid[0] ? exc_q[head_q]    : 1'b0;
    dec_cause0 = dec_valid[0] ? cause_q[head_q]  : '0;
    dec_pc1    = dec_valid[1] ? pc_q[head_p1]    : '0;
    dec_inst1  = dec_valid[1] ? inst_q[head_p1]  : '0;
    dec_exc1   = dec_valid[1] ? exc_q[head_p1]   : 1'b0;
    dec_cause1 = dec_valid[1] ? cause_q[head_p1] : '0;
  end

endmodule
